// File: rtl/hr_measure_ctrl.sv
`timescale 1ns/1ps
// Heart-rate measurement controller: counts debounced beat edges over a fixed
// tick window and converts the count to beats per minute.
module hr_measure_ctrl #(
   parameter int WIN_MS     = 15000,
   parameter int REFRACT_MS = 250,
   parameter int MULT       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       start,
   input  logic       tick,
   input  logic       pulse,
   output logic       kick_en,
   output logic       busy,
   output logic [7:0] bpm,
   output logic       bpm_valid,
   output logic       aborted,
   output logic [1:0] state_dbg
);

   // start, tick, bpm_valid and aborted are single-cycle strobes with no
   // back-pressure: a strobe is consumed in the cycle it is high or not at all.

   localparam int TW = $clog2(WIN_MS + 1);
   localparam int RW = (REFRACT_MS < 1) ? 1 : $clog2(REFRACT_MS + 1);
   localparam int PW = 8 + $clog2(MULT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(WIN_MS - 1);
   localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT_MS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      CALC    = 2'd2
   } state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic [7:0]    beat_cnt;
   logic [RW-1:0] refr_cnt;
   logic [2:0]    sync_q;
   logic          beat_edge;
   logic [PW-1:0] prod;
   logic [7:0]    bpm_sat;

   // sync_q[1:0] is the synchronizer; sync_q[2] holds the previous synced level
   assign beat_edge = sync_q[1] & ~sync_q[2];
   assign prod      = PW'(beat_cnt) * PW'(MULT);
   assign bpm_sat   = (prod > PW'(255)) ? 8'hFF : prod[7:0];
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         beat_cnt  <= '0;
         refr_cnt  <= '0;
         sync_q    <= '0;
         kick_en   <= 1'b0;
         busy      <= 1'b0;
         bpm       <= '0;
         bpm_valid <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[1:0], pulse};
         bpm_valid <= 1'b0;
         aborted   <= 1'b0;
         case (state)
            IDLE: begin
               if (start && enable) begin
                  state    <= MEASURE;
                  kick_en  <= 1'b1;
                  busy     <= 1'b1;
                  tick_cnt <= '0;
                  beat_cnt <= '0;
                  refr_cnt <= '0;
               end
            end
            MEASURE: begin
               if (!enable) begin
                  state   <= IDLE;
                  kick_en <= 1'b0;
                  busy    <= 1'b0;
                  aborted <= 1'b1;
               end else begin
                  if (tick) begin
                     tick_cnt <= tick_cnt + TW'(1);
                  end
                  // A counted edge reloads the refractory window; that load
                  // takes precedence over a same-cycle tick decrement.
                  if (beat_edge && (refr_cnt == '0)) begin
                     refr_cnt <= REFR_LOAD;
                     if (beat_cnt != 8'hFF) begin
                        beat_cnt <= beat_cnt + 8'd1;
                     end
                  end else if (tick && (refr_cnt != '0)) begin
                     refr_cnt <= refr_cnt - RW'(1);
                  end
                  if (tick && (tick_cnt == TICK_LAST)) begin
                     state   <= CALC;
                     kick_en <= 1'b0;
                  end
               end
            end
            CALC: begin
               bpm       <= bpm_sat;
               bpm_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state   <= IDLE;
               kick_en <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hr_measure_ctrl.sv
`timescale 1ns/1ps
// Directed bench for hr_measure_ctrl with a short window (600 ticks),
// 5-tick refractory period and a x100 bpm scale.
module tb_hr_measure_ctrl;

   localparam int WIN  = 600;
   localparam int REFR = 5;
   localparam int MUL  = 100;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       start;
   logic       tick;
   logic       pulse;
   logic       kick_en;
   logic       busy;
   logic [7:0] bpm;
   logic       bpm_valid;
   logic       aborted;
   logic [1:0] state_dbg;

   int checks;
   int errors;
   int kick_hits;
   int valid_cnt;
   int abort_cnt;
   logic [7:0] exp_q[$];
   bit beat_at[0:1023];

   hr_measure_ctrl #(
      .WIN_MS    (WIN),
      .REFRACT_MS(REFR),
      .MULT      (MUL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .start    (start),
      .tick     (tick),
      .pulse    (pulse),
      .kick_en  (kick_en),
      .busy     (busy),
      .bpm      (bpm),
      .bpm_valid(bpm_valid),
      .aborted  (aborted),
      .state_dbg(state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // scoreboard: every bpm_valid strobe must match the next queued result
   always @(negedge clk) begin
      if (rst && bpm_valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
         else check("sb_bpm", 32'(bpm), 32'(exp_q.pop_front()));
      end
      if (aborted) abort_cnt++;
   end

   // driver tasks
   task automatic clear_beats();
      for (int i = 0; i < 1024; i++) beat_at[i] = 1'b0;
   endtask

   task automatic start_meas();
      @(negedge clk);
      start = 1'b1;
      tick  = 1'b0;
      pulse = 1'b0;
      @(negedge clk);
      start = 1'b0;
      kick_hits = 0;
   endtask

   // Each tick spans two cycles. The synchronizer adds two cycles, so pulse
   // raised during tick k produces an edge in the cycle of tick k+1.
   task automatic run_ticks(input int n, input int restart_at);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (kick_en) kick_hits++;
         tick  = 1'b1;
         pulse = beat_at[k+1];
         start = (k == restart_at);
         @(negedge clk);
         tick  = 1'b0;
         start = 1'b0;
         pulse = beat_at[k+1];
      end
   endtask

   task automatic finish_check(input logic [7:0] exp_bpm, input string tag);
      check({tag, "_calc_kick"}, 32'(kick_en), 32'd0);
      check({tag, "_calc_busy"}, 32'(busy), 32'd1);
      check({tag, "_calc_valid"}, 32'(bpm_valid), 32'd0);
      @(negedge clk);
      check({tag, "_valid"}, 32'(bpm_valid), 32'd1);
      check({tag, "_bpm"}, 32'(bpm), 32'(exp_bpm));
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_no_abort"}, 32'(aborted), 32'd0);
      @(negedge clk);
      check({tag, "_valid_off"}, 32'(bpm_valid), 32'd0);
      check({tag, "_kick_ticks"}, 32'(kick_hits), 32'(WIN));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      kick_hits = 0;
      valid_cnt = 0;
      abort_cnt = 0;
      rst    = 1'b0;
      enable = 1'b0;
      start  = 1'b0;
      tick   = 1'b0;
      pulse  = 1'b0;
      clear_beats();

      repeat (3) @(negedge clk);
      check("rst_kick", 32'(kick_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bpm", 32'(bpm), 32'd0);
      check("rst_valid", 32'(bpm_valid), 32'd0);
      check("rst_abort", 32'(aborted), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      enable = 1'b1;

      // scenario 1: two beats -> 200 bpm
      clear_beats();
      beat_at[100] = 1'b1;
      beat_at[200] = 1'b1;
      exp_q.push_back(8'd200);
      start_meas();
      check("s1_busy_on", 32'(busy), 32'd1);
      check("s1_kick_on", 32'(kick_en), 32'd1);
      check("s1_state", 32'(state_dbg), 32'd1);
      run_ticks(WIN, 0);
      finish_check(8'd200, "s1");

      // scenario 2: three beats -> 300 saturates to 255
      clear_beats();
      beat_at[100] = 1'b1;
      beat_at[200] = 1'b1;
      beat_at[300] = 1'b1;
      exp_q.push_back(8'd255);
      start_meas();
      run_ticks(WIN, 0);
      finish_check(8'd255, "s2");

      // scenario 4: start ignored while disabled, then abort mid-window
      enable = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("s4_idle_busy", 32'(busy), 32'd0);
      check("s4_idle_kick", 32'(kick_en), 32'd0);
      check("s4_idle_state", 32'(state_dbg), 32'd0);
      enable = 1'b1;
      clear_beats();
      beat_at[100] = 1'b1;
      start_meas();
      run_ticks(300, 0);
      enable = 1'b0;
      @(negedge clk);
      check("s4_aborted", 32'(aborted), 32'd1);
      check("s4_bpm_kept", 32'(bpm), 32'd255);
      check("s4_no_valid", 32'(bpm_valid), 32'd0);
      check("s4_busy_off", 32'(busy), 32'd0);
      check("s4_kick_off", 32'(kick_en), 32'd0);
      @(negedge clk);
      check("s4_abort_off", 32'(aborted), 32'd0);
      check("s4_bpm_hold", 32'(bpm), 32'd255);
      enable = 1'b1;

      // scenario 3: refractory rejects the beat 3 ticks after a counted one;
      // enable also drops during CALC, which must not abort
      clear_beats();
      beat_at[100] = 1'b1;
      beat_at[103] = 1'b1;
      beat_at[106] = 1'b1;
      exp_q.push_back(8'd200);
      start_meas();
      run_ticks(WIN, 0);
      enable = 1'b0;
      finish_check(8'd200, "s3");
      enable = 1'b1;

      // scenario 6: beat on the final tick counts; mid-window start ignored
      clear_beats();
      beat_at[300] = 1'b1;
      beat_at[600] = 1'b1;
      exp_q.push_back(8'd200);
      start_meas();
      run_ticks(WIN, 250);
      finish_check(8'd200, "s6");

      // scenario 5: reset mid-window, then a fresh measurement
      clear_beats();
      beat_at[100] = 1'b1;
      start_meas();
      run_ticks(300, 0);
      rst = 1'b0;
      #1;
      check("s5_rst_kick", 32'(kick_en), 32'd0);
      check("s5_rst_busy", 32'(busy), 32'd0);
      check("s5_rst_bpm", 32'(bpm), 32'd0);
      check("s5_rst_valid", 32'(bpm_valid), 32'd0);
      check("s5_rst_abort", 32'(aborted), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("s5_post_abort", 32'(aborted), 32'd0);
      check("s5_post_busy", 32'(busy), 32'd0);
      check("s5_post_state", 32'(state_dbg), 32'd0);
      clear_beats();
      beat_at[50]  = 1'b1;
      beat_at[150] = 1'b1;
      exp_q.push_back(8'd200);
      start_meas();
      run_ticks(WIN, 0);
      finish_check(8'd200, "s5");

      // final report
      @(negedge clk);
      check("valid_count", 32'(valid_cnt), 32'd5);
      check("abort_count", 32'(abort_cnt), 32'd1);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
